// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the 1024x32 instruction store
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [16:0]     DEPTH_W = 17'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM
  } state_t;

  state_t state, state_nxt;

  logic [7:0]      len_hi;     // high length byte, held until LEN_LO arrives
  logic [15:0]     len;        // word count N of the current frame
  logic [ADDR_W:0] word_cnt;   // one extra bit so N == DEPTH is representable
  logic [1:0]      byte_idx;   // position of the next payload byte within its word
  logic [23:0]     asm_q;      // first three bytes of the word being assembled
  logic [7:0]      acc;        // running payload checksum

  logic        accept;
  logic [15:0] len_in;
  logic        len_bad;
  logic        last_word;

  // Handshake and busy are pure state decodes so in_valid never reaches in_ready.
  assign in_ready = (state != S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;

  assign len_in    = {len_hi, in_data};
  assign len_bad   = (len_in == 16'd0) || ({1'b0, len_in} > DEPTH_W);
  assign last_word = (byte_idx == 2'd3) &&
                     ({{(15-ADDR_W){1'b0}}, word_cnt} == (len - 16'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: every non-idle state advances only on an accepted byte.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start)    state_nxt = S_LEN_HI;
      S_LEN_HI: if (in_valid) state_nxt = S_LEN_LO;
      S_LEN_LO: if (in_valid) state_nxt = len_bad ? S_IDLE : S_DATA;
      S_DATA:   if (in_valid && last_word) state_nxt = S_CSUM;
      S_CSUM:   if (in_valid) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, write strobe, checksum and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi   <= 8'd0;
      len      <= 16'd0;
      word_cnt <= '0;
      byte_idx <= 2'd0;
      asm_q    <= 24'd0;
      acc      <= 8'd0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= 32'd0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            acc      <= 8'd0;
            word_cnt <= '0;
            byte_idx <= 2'd0;
          end
        end
        S_LEN_HI: begin
          if (accept) len_hi <= in_data;
        end
        S_LEN_LO: begin
          if (accept) begin
            len <= len_in;
            if (len_bad) begin
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            acc      <= acc + in_data;
            asm_q    <= {asm_q[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              we       <= 1'b1;
              waddr    <= word_cnt[ADDR_W-1:0];
              wdata    <= {asm_q, in_data};
              word_cnt <= word_cnt + CNT_ONE;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            done <= 1'b1;
            err  <= (in_data != acc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with randomized frames
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int          passed = 0;
  int          total  = 0;
  longint      cyc    = 0;
  logic [41:0] exp_wr[$];    // {waddr, wdata} expected in order
  logic        exp_done[$];  // expected err value at each done pulse
  longint      we_cyc[$];    // cycle stamps of observed writes
  logic [31:0] payload[$];   // words of the frame about to be sent
  logic [41:0] mon_e;
  logic        mon_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: pop the scoreboard whenever the loader writes or finishes a frame.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (we) begin
        we_cyc.push_back(cyc);
        if (exp_wr.size() == 0) begin
          total++;
          $display("FAIL unexpected_we: got waddr %0h wdata %0h expected no write", waddr, wdata);
        end else begin
          mon_e = exp_wr.pop_front();
          check("waddr", 64'(waddr), 64'(mon_e[41:32]));
          check("wdata", 64'(wdata), 64'(mon_e[31:0]));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          mon_d = exp_done.pop_front();
          check("done_err", 64'(err), 64'(mon_d));
          check("done_busy", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse_start);
    int   t;
    int   n;
    logic rdy;
    if (gaps) begin
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      in_valid = 1'b0;
      repeat (n) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = pulse_start;
    t = 0;
    forever begin
      rdy = in_ready;
      tick();
      start = 1'b0;
      if (rdy) break;
      t++;
      if (t > 20) begin
        total++;
        $display("FAIL handshake_timeout: got in_ready=0 for %0d cycles expected 1", t);
        break;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_cleared", 64'(err), 64'd0);
  endtask

  // Sends one frame built from payload; csum_force < 0 means send the correct checksum.
  task automatic run_frame(input int n, input int csum_force, input bit gaps, input int pulse_at);
    int          s;
    logic [7:0]  good_cs;
    logic [7:0]  cs;
    bit          len_ok;
    bit          exp_err;
    logic [15:0] n16;
    n16    = 16'(n);
    len_ok = (n >= 1) && (n <= DEPTH);
    s = 0;
    if (len_ok) begin
      for (int i = 0; i < n; i++) begin
        s += int'(payload[i][31:24]) + int'(payload[i][23:16]) +
             int'(payload[i][15:8])  + int'(payload[i][7:0]);
        exp_wr.push_back({10'(i), payload[i]});
      end
    end
    good_cs = 8'(s % 256);
    cs      = (csum_force < 0) ? good_cs : 8'(csum_force);
    exp_err = !len_ok || (cs != good_cs);
    exp_done.push_back(exp_err);

    do_start();
    send_byte(n16[15:8], gaps, 1'b0);
    send_byte(n16[7:0],  gaps, 1'b0);
    if (len_ok) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          send_byte(payload[i][31-8*k -: 8], gaps, (i*4 + k) == pulse_at);
          if (k == 3) check("we_latency", 64'(we), 64'd1);
        end
      end
      send_byte(cs, gaps, 1'b0);
    end
    in_valid = 1'b0;
    check("done_latency", 64'(done), 64'd1);
    check("err_at_done", 64'(err), 64'(exp_err));
    check("busy_drop", 64'(busy), 64'd0);
    tick();
    check("scoreboard_drained", 64'(exp_wr.size() + exp_done.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_we"},       64'(we),       64'd0);
    check({tag, "_waddr"},    64'(waddr),    64'd0);
    check({tag, "_wdata"},    64'(wdata),    64'd0);
    check({tag, "_busy"},     64'(busy),     64'd0);
    check({tag, "_done"},     64'(done),     64'd0);
    check({tag, "_err"},      64'(err),      64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Single word, correct checksum 38.
    payload = {32'hDEADBEEF};
    run_frame(1, 8'h38, 1'b0, -1);

    // Three words back to back with a stray start mid-payload; writes 4 cycles apart.
    payload = {32'h00000001, 32'h00000002, 32'h00000003};
    we_cyc.delete();
    run_frame(3, 8'h06, 1'b0, 5);
    check("three_we_count", 64'(we_cyc.size()), 64'd3);
    if (we_cyc.size() == 3) begin
      check("we_spacing_01", 64'(we_cyc[1] - we_cyc[0]), 64'd4);
      check("we_spacing_12", 64'(we_cyc[2] - we_cyc[1]), 64'd4);
    end

    // Bad checksum: write still happens, err sticks until the next start.
    payload = {32'hDEADBEEF};
    run_frame(1, 0, 1'b0, -1);
    repeat (5) tick();
    check("err_sticky", 64'(err), 64'd1);

    // Length errors.
    payload.delete();
    run_frame(0, -1, 1'b0, -1);
    run_frame(16'h0401, -1, 1'b0, -1);

    // Reset after 6 payload bytes, with a stray start inside the payload.
    payload = {32'hCAFEF00D, 32'h12345678};
    exp_wr.push_back({10'd0, 32'hCAFEF00D});
    do_start();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++)
      send_byte(payload[j/4][31-8*(j%4) -: 8], 1'b0, j == 2);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;
    repeat (5) tick();
    check("midrst_one_write", 64'(exp_wr.size()), 64'd0);
    run_frame(2, -1, 1'b0, -1);

    // Random small frames, some with corrupted checksums, random stalls.
    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(1, 9));
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back($urandom);
      run_frame(n, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1,
                1'b1, int'($urandom_range(0, 40)));
    end

    // Full depth with stalls; last write lands at 3FF.
    payload.delete();
    for (int i = 0; i < DEPTH; i++) payload.push_back($urandom);
    we_cyc.delete();
    run_frame(DEPTH, -1, 1'b1, -1);
    check("full_we_count", 64'(we_cyc.size()), 64'(DEPTH));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
